rf_context_mover: RTL and testbench

- Sequencer that moves whole register contexts between the multi-bank register file and data memory.
- SAVE: reads all 32 registers of one bank through a read port and writes them to memory.
- RESTORE: reads 31 words from memory and writes them into one bank's x1..x31 through the write port.
- Sits beside the core. It arbitrates onto the register-file bank select and port signals during context switches and is driven by a trap/scheduler command.

---
 rtl/rf_context_mover_pkg.sv | 25 ++
 rtl/rf_context_mover.sv | 156 +++++++++++++++
 tb/tb_rf_context_mover.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_context_mover_pkg.sv
// Shared types and constants for the register-context mover.
package rx32_ctx_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SAVE_REQ = 3'd1,
    LOAD_REQ = 3'd2,
    LOAD_WB  = 3'd3,
    DONE     = 3'd4,
    ERR      = 3'd5
  } ctx_state_t;

  typedef enum logic {
    OP_SAVE    = 1'b0,
    OP_RESTORE = 1'b1
  } ctx_op_t;

  localparam int NUM_REGS   = 32;
  localparam int WORD_BYTES = 4;

  // Index of the final register; the walk ends by comparing against this,
  // never by letting the 5-bit index wrap.
  localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);

endpackage

// File: rtl/rf_context_mover.sv
// Moves a whole register bank to memory (SAVE, x0..x31) or from memory back
// into a bank (RESTORE, x1..x31). One memory word per register, addressed
// as base + 4*idx with natural wrap-around in AW bits.
//
// Handshakes: a command is taken on a clock edge where cmd_valid and
// cmd_ready are both high; cmd_ready is high only while idle, so cmd_valid
// in any other cycle is ignored. A memory transfer completes on an edge
// where mem_req and mem_ack are both high; until then every memory output
// stays constant. mem_ack while mem_req is low has no effect.
module rf_context_mover
  import rx32_ctx_pkg::*;
#(
  parameter int NUM_BANKS = 5,
  parameter int AW        = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_op,
  input  logic [2:0]    cmd_bank,
  input  logic [AW-1:0] cmd_base,
  output logic          done,
  output logic          error,
  output logic [2:0]    rf_sel_read,
  output logic [4:0]    rf_RA1,
  input  logic [31:0]   rf_RD1,
  output logic [2:0]    rf_sel_write,
  output logic          rf_WE3,
  output logic [4:0]    rf_WA3,
  output logic [31:0]   rf_WD3,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  input  logic          mem_ack,
  output logic [2:0]    dbg_state
);

  localparam logic [3:0] NB = 4'(NUM_BANKS);

  ctx_state_t    state_q;
  logic          ready_q;
  logic [4:0]    idx_q;
  logic [2:0]    bank_q;
  logic [AW-1:0] base_q;
  logic [31:0]   data_q;
  logic [AW-1:0] offset;

  assign offset    = AW'({idx_q, 2'b00});
  assign cmd_ready = ready_q & ~rst;
  assign dbg_state = state_q;

  // Sequencer: command capture, register walk and memory handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      idx_q   <= 5'd0;
      bank_q  <= 3'd0;
      base_q  <= '0;
      data_q  <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          if (ready_q && cmd_valid) begin
            ready_q <= 1'b0;
            bank_q  <= cmd_bank;
            base_q  <= cmd_base & ~AW'(3);
            if ({1'b0, cmd_bank} >= NB) begin
              state_q <= ERR;
            end else if (cmd_op == OP_RESTORE) begin
              state_q <= LOAD_REQ;
              idx_q   <= 5'd1;
            end else begin
              state_q <= SAVE_REQ;
              idx_q   <= 5'd0;
            end
          end
        end
        SAVE_REQ: begin
          if (mem_ack) begin
            if (idx_q == LAST_IDX) state_q <= DONE;
            else idx_q <= idx_q + 5'd1;
          end
        end
        LOAD_REQ: begin
          if (mem_ack) begin
            data_q  <= mem_rdata;
            state_q <= LOAD_WB;
          end
        end
        LOAD_WB: begin
          if (idx_q == LAST_IDX) begin
            state_q <= DONE;
          end else begin
            idx_q   <= idx_q + 5'd1;
            state_q <= LOAD_REQ;
          end
        end
        DONE, ERR: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          idx_q   <= 5'd0;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Port drive decoded from the registered state; only mem_wdata passes the
  // register-file read data straight through.
  always_comb begin
    done         = 1'b0;
    error        = 1'b0;
    rf_sel_read  = 3'd0;
    rf_RA1       = 5'd0;
    rf_sel_write = 3'd0;
    rf_WE3       = 1'b0;
    rf_WA3       = 5'd0;
    rf_WD3       = 32'd0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = 32'd0;
    case (state_q)
      SAVE_REQ: begin
        rf_sel_read = bank_q;
        rf_RA1      = idx_q;
        mem_req     = 1'b1;
        mem_we      = 1'b1;
        mem_addr    = base_q + offset;
        mem_wdata   = rf_RD1;
      end
      LOAD_REQ: begin
        mem_req  = 1'b1;
        mem_addr = base_q + offset;
      end
      LOAD_WB: begin
        rf_WE3       = 1'b1;
        rf_sel_write = bank_q;
        rf_WA3       = idx_q;
        rf_WD3       = data_q;
      end
      DONE:    done  = 1'b1;
      ERR:     error = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rf_context_mover.sv
// Bench for rf_context_mover: emulates a 5-bank register file and a sparse
// memory, predicts every memory transfer and register write from the
// command alone, and checks the DUT against those predictions each cycle.
module tb_rf_context_mover;

  logic        clk, rst;
  logic        cmd_valid, cmd_ready, cmd_op;
  logic [2:0]  cmd_bank;
  logic [31:0] cmd_base;
  logic        done, error;
  logic [2:0]  rf_sel_read, rf_sel_write, dbg_state;
  logic [4:0]  rf_RA1, rf_WA3;
  logic [31:0] rf_RD1, rf_WD3;
  logic        rf_WE3;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  rf_context_mover #(.NUM_BANKS(5), .AW(32)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_bank(cmd_bank), .cmd_base(cmd_base),
    .done(done), .error(error),
    .rf_sel_read(rf_sel_read), .rf_RA1(rf_RA1), .rf_RD1(rf_RD1),
    .rf_sel_write(rf_sel_write), .rf_WE3(rf_WE3), .rf_WA3(rf_WA3), .rf_WD3(rf_WD3),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- environment models ----------------
  logic [31:0] rf_arr [5][32];   // register file seen by the DUT
  logic [31:0] rf_ref [5][32];   // expected register contents
  logic [31:0] mem [logic [31:0]];
  int          max_wait;
  int          req_age, wait_target;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'h5A5A_A5A5;
  endfunction

  assign rf_RD1  = (rf_sel_read < 3'd5) ? rf_arr[rf_sel_read][rf_RA1] : 32'h0;
  assign mem_ack = mem_req && (req_age >= wait_target);

  always @(posedge clk) begin
    if (rf_WE3 && rf_sel_write < 3'd5) rf_arr[rf_sel_write][rf_WA3] <= rf_WD3;
  end

  // Memory latency: each request waits a fresh random 0..max_wait cycles.
  always @(posedge clk) begin
    if (!mem_req || mem_ack) begin
      req_age     <= 0;
      wait_target <= $urandom_range(0, max_wait);
    end else begin
      req_age <= req_age + 1;
    end
  end

  // ---------------- scoreboard ----------------
  int          n_checks, n_fail;
  logic [64:0] exp_q[$];          // {we, addr, wdata(0 for reads)}
  logic [39:0] rf_q[$];           // {bank, reg, data}
  logic [31:0] act_addr_q[$];
  int          xfer_cnt, rf_we_cnt;
  bit          read_2000, prev_wait;
  logic [64:0] prev_bus;

  task automatic check(input string name, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Compare process: every acked transfer and register write against the queues.
  always @(negedge clk) begin
    logic [64:0] cur;
    logic [39:0] cur_rf;
    if (rst) begin
      prev_wait = 0;
    end else begin
      if (mem_req) begin
        if (prev_wait) check("mem_hold", {mem_we, mem_addr, mem_wdata}, prev_bus);
        cur = {mem_we, mem_addr, (mem_we ? mem_wdata : 32'h0)};
        if (mem_ack) begin
          xfer_cnt++;
          act_addr_q.push_back(mem_addr);
          if (!mem_we && mem_addr == 32'h2000) read_2000 = 1;
          if (exp_q.size() == 0) check("mem_unexpected", 1, 0);
          else check("mem_xfer", cur, exp_q.pop_front());
          if (mem_we) mem[mem_addr] = mem_wdata;
          prev_wait = 0;
        end else begin
          prev_wait = 1;
          prev_bus  = {mem_we, mem_addr, mem_wdata};
        end
      end else begin
        prev_wait = 0;
      end
      if (rf_WE3) begin
        rf_we_cnt++;
        cur_rf = {rf_sel_write, rf_WA3, rf_WD3};
        if (rf_q.size() == 0) check("rf_unexpected", 1, 0);
        else check("rf_write", cur_rf, rf_q.pop_front());
      end
    end
    mem_rdata = mem_rd(mem_addr);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Predict the whole command from its definition: SAVE stores x0..x31,
  // RESTORE loads x1..x31, word i lives at aligned base + 4*i.
  task automatic build_expect(input logic op, input logic [2:0] bank, input logic [31:0] ba);
    logic [31:0] a;
    if (bank >= 3'd5) return;
    if (op == 1'b0) begin
      for (int i = 0; i < 32; i++) exp_q.push_back({1'b1, ba + 32'(4 * i), rf_ref[bank][i]});
    end else begin
      for (int i = 1; i < 32; i++) begin
        a = ba + 32'(4 * i);
        exp_q.push_back({1'b0, a, 32'h0});
        rf_q.push_back({bank, 5'(i), mem_rd(a)});
        rf_ref[bank][i] = mem_rd(a);
      end
    end
  endtask

  task automatic check_bank(input int b);
    int bad = 0;
    for (int i = 0; i < 32; i++) if (rf_arr[b][i] !== rf_ref[b][i]) bad++;
    check($sformatf("bank%0d_contents", b), bad, 0);
  endtask

  task automatic run_cmd(input logic op, input logic [2:0] bank, input logic [31:0] base,
                         input int mw, input bit noise, output int lat);
    logic [31:0] ba;
    bit          bad, fin;
    int          k, mism;
    ba  = base & ~32'h3;
    bad = (bank >= 3'd5);
    max_wait = mw;
    k = 0;
    while (!cmd_ready && k < 100) begin tick(); k++; end
    check("cmd_ready_idle", cmd_ready, 1);
    build_expect(op, bank, ba);
    xfer_cnt = 0;
    act_addr_q.delete();
    cmd_valid = 1; cmd_op = op; cmd_bank = bank; cmd_base = base;
    lat = 0; fin = 0;
    while (!fin && lat < 5000) begin
      tick();
      lat++;
      if (done || error) fin = 1;
      else if (noise) begin
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_op    = 1'($urandom_range(0, 1));
        cmd_bank  = 3'($urandom_range(0, 7));
        cmd_base  = $urandom;
      end else cmd_valid = 0;
    end
    cmd_valid = 0;
    check("cmd_finished", fin, 1);
    check("done_or_error", {done, error}, bad ? 2'b01 : 2'b10);
    if (bad) begin
      check("err_quiet", {mem_req, rf_WE3}, 2'b00);
      tick();
      check("err_ready_after", cmd_ready, 1);
    end
    check("exp_q_drained", exp_q.size(), 0);
    check("rf_q_drained", rf_q.size(), 0);
    check("xfer_count", xfer_cnt, bad ? 0 : (op ? 31 : 32));
    if (!bad && op == 1'b0) begin
      mism = 0;
      for (int i = 0; i < 32; i++) if (mem_rd(ba + 32'(4 * i)) !== rf_ref[bank][i]) mism++;
      check("save_mem_image", mism, 0);
    end
    exp_q.delete();
    rf_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat, k, we_before;
    logic [31:0] saved [32];
    logic [31:0] b3;

    n_checks = 0; n_fail = 0; xfer_cnt = 0; rf_we_cnt = 0; read_2000 = 0;
    max_wait = 0; prev_wait = 0; mem_rdata = 0;
    rst = 1; cmd_valid = 0; cmd_op = 0; cmd_bank = 0; cmd_base = 0;
    for (int b = 0; b < 5; b++)
      for (int i = 0; i < 32; i++) begin
        rf_arr[b][i] = (i == 0) ? 32'h0 : ((b == 2) ? 32'hA000_0000 + 32'(i) : $urandom);
        rf_ref[b][i] = rf_arr[b][i];
      end

    // Reset state
    repeat (3) tick();
    check("rst_outputs_zero",
          |{cmd_ready, done, error, rf_sel_read, rf_RA1, rf_sel_write, rf_WE3, rf_WA3,
            rf_WD3, mem_req, mem_we, mem_addr, mem_wdata}, 1'b0);
    rst = 0;
    tick();
    check("ready_after_rst", cmd_ready, 1);
    check("idle_outputs_zero", |{done, error, mem_req, rf_WE3, mem_addr}, 1'b0);

    // SAVE bank 2 to 0x1000, zero-wait memory
    we_before = rf_we_cnt;
    run_cmd(1'b0, 3'd2, 32'h1000, 0, 0, lat);
    check("save_latency", lat, 33);
    check("save_word0", mem_rd(32'h1000), 32'h0);
    check("save_word31", mem_rd(32'h107C), 32'hA000_001F);
    check("save_no_rf_write", rf_we_cnt - we_before, 0);

    // RESTORE bank 4 from 0x2000
    for (int i = 0; i < 32; i++) mem[32'h2000 + 32'(4 * i)] = 32'h5500_0000 + 32'(i);
    read_2000 = 0;
    run_cmd(1'b1, 3'd4, 32'h2000, 0, 0, lat);
    check("restore_latency", lat, 63);
    check("restore_x1", rf_arr[4][1], 32'h5500_0001);
    check("restore_x31", rf_arr[4][31], 32'h5500_001F);
    check("restore_no_word0", read_2000, 0);
    for (int b = 0; b < 5; b++) check_bank(b);

    // SAVE with random ack delays and cmd_valid noise while busy
    run_cmd(1'b0, 3'd0, 32'h0000_4000, 5, 1, lat);

    // Out-of-range banks
    run_cmd(1'b0, 3'd5, 32'h3000, 0, 0, lat);
    check("err5_latency", lat, 1);
    run_cmd(1'b1, 3'd7, 32'h3000, 0, 0, lat);
    check("err7_latency", lat, 1);

    // Address wrap-around with misaligned base
    run_cmd(1'b0, 3'd1, 32'hFFFF_FFC3, 0, 0, lat);
    check("wrap_count", act_addr_q.size(), 32);
    if (act_addr_q.size() == 32) begin
      check("wrap_first", act_addr_q[0], 32'hFFFF_FFC0);
      check("wrap_top", act_addr_q[15], 32'hFFFF_FFFC);
      check("wrap_zero", act_addr_q[16], 32'h0000_0000);
      check("wrap_last", act_addr_q[31], 32'h0000_003C);
    end

    // Random commands
    for (int n = 0; n < 8; n++) begin
      run_cmd(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
              $urandom, $urandom_range(0, 3), 1'($urandom_range(0, 1)), lat);
    end
    for (int b = 0; b < 5; b++) check_bank(b);

    // Reset in the middle of a RESTORE into bank 3, just as idx reaches 10
    for (int i = 0; i < 32; i++) saved[i] = rf_ref[3][i];
    b3 = 32'h0000_8000;
    max_wait = 0;
    tick();
    check("pre_rst_ready", cmd_ready, 1);
    build_expect(1'b1, 3'd3, b3);
    cmd_valid = 1; cmd_op = 1; cmd_bank = 3; cmd_base = b3;
    tick();
    cmd_valid = 0;
    k = 0;
    while (!(rf_WE3 && rf_WA3 == 5'd9) && k < 200) begin tick(); k++; end
    check("reached_x9", {rf_WE3, rf_WA3}, {1'b1, 5'd9});
    tick();
    rst = 1;
    tick();
    check("rst_mid_quiet", {mem_req, rf_WE3, cmd_ready, done}, 4'b0000);
    rst = 0;
    exp_q.delete();
    rf_q.delete();
    tick();
    check("rst_mid_ready", cmd_ready, 1);
    for (int i = 10; i < 32; i++) rf_ref[3][i] = saved[i];
    check_bank(3);

    // Fresh SAVE after the interrupted restore
    run_cmd(1'b0, 3'd3, 32'h0000_9000, 0, 0, lat);
    check("post_rst_save_latency", lat, 33);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
